// File: rtl/stage_memory.sv
// stage_memory: RV32 memory-access pipeline stage.
// Issues one load/store at a time over a req/ack data-memory port, aligns
// store data, extracts and extends load data, and registers the write-back slot.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip the bus and retire with o_Misaligned=1; otherwise low address bits are ignored).
module stage_memory (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Valid,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [1:0]  i_MemSize,
    input  logic        i_MemUnsigned,
    input  logic        i_RegWrite,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_AluOutput,
    input  logic [31:0] i_rs2Value,
    output logic        o_Stall,
    output logic        o_DmemReq,
    output logic        o_DmemWe,
    output logic [31:0] o_DmemAddr,
    output logic [31:0] o_DmemWdata,
    output logic [3:0]  o_DmemByteEn,
    input  logic        i_DmemAck,
    input  logic [31:0] i_DmemRdata,
    output logic        o_Valid,
    output logic        o_RegWrite,
    output logic [4:0]  o_rd,
    output logic [31:0] o_WriteData,
    output logic        o_Misaligned
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        mem_op;
    logic        misaligned;
    logic [3:0]  st_byteen;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Access context held while the request is in flight
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic        lat_load;
    logic        lat_regwrite;
    logic [4:0]  lat_rd;

    assign o_Stall = (state != IDLE);
    assign accept  = i_Valid && (state == IDLE);
    assign mem_op  = i_MemRead || i_MemWrite;

    // Misalignment detection, only meaningful when the trap feature is built in
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op &&
                        ((i_MemSize == 2'b01 && i_AluOutput[0]) ||
                         (i_MemSize[1] && (i_AluOutput[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering: byte enables and lane-replicated data
    always_comb begin
        st_byteen = 4'b1111;
        st_wdata  = i_rs2Value;
        if (i_MemRead) begin
            st_byteen = 4'b1111;
        end else if (i_MemSize == 2'b00) begin
            st_byteen = 4'b0001 << i_AluOutput[1:0];
            st_wdata  = {4{i_rs2Value[7:0]}};
        end else if (i_MemSize == 2'b01) begin
            st_byteen = 4'b0011 << {i_AluOutput[1], 1'b0};
            st_wdata  = {2{i_rs2Value[15:0]}};
        end
    end

    // Load lane extraction with sign or zero extension
    always_comb begin
        ld_byte = 8'h00;
        case (lat_lane)
            2'd0:    ld_byte = i_DmemRdata[7:0];
            2'd1:    ld_byte = i_DmemRdata[15:8];
            2'd2:    ld_byte = i_DmemRdata[23:16];
            default: ld_byte = i_DmemRdata[31:24];
        endcase
        ld_half = lat_lane[1] ? i_DmemRdata[31:16] : i_DmemRdata[15:0];
        ld_data = i_DmemRdata;
        if (!lat_size[1]) begin
            if (lat_size[0]) begin
                ld_data = {{16{~lat_unsigned & ld_half[15]}}, ld_half};
            end else begin
                ld_data = {{24{~lat_unsigned & ld_byte[7]}}, ld_byte};
            end
        end
    end

    // State register
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && mem_op && !misaligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (i_DmemAck) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered bus request, access context and write-back slot
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            o_DmemReq    <= 1'b0;
            o_DmemWe     <= 1'b0;
            o_DmemAddr   <= 32'h0;
            o_DmemWdata  <= 32'h0;
            o_DmemByteEn <= 4'h0;
            o_Valid      <= 1'b0;
            o_RegWrite   <= 1'b0;
            o_rd         <= 5'h0;
            o_WriteData  <= 32'h0;
            o_Misaligned <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
            lat_load     <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_rd       <= 5'h0;
        end else begin
            o_Valid      <= 1'b0;
            o_Misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mem_op) begin
                            o_Valid     <= 1'b1;
                            o_RegWrite  <= i_RegWrite;
                            o_rd        <= i_rd;
                            o_WriteData <= i_AluOutput;
                        end else if (misaligned) begin
                            o_Valid      <= 1'b1;
                            o_Misaligned <= 1'b1;
                            o_RegWrite   <= 1'b0;
                            o_rd         <= i_rd;
                            o_WriteData  <= 32'h0;
                        end else begin
                            o_DmemReq    <= 1'b1;
                            o_DmemWe     <= i_MemWrite;
                            o_DmemAddr   <= {i_AluOutput[31:2], 2'b00};
                            o_DmemWdata  <= st_wdata;
                            o_DmemByteEn <= st_byteen;
                            lat_size     <= i_MemSize;
                            lat_unsigned <= i_MemUnsigned;
                            lat_lane     <= i_AluOutput[1:0];
                            lat_load     <= i_MemRead;
                            lat_regwrite <= i_RegWrite && i_MemRead;
                            lat_rd       <= i_rd;
                        end
                    end
                end
                REQ: begin
                    if (i_DmemAck) begin
                        o_DmemReq   <= 1'b0;
                        o_DmemWe    <= 1'b0;
                        o_Valid     <= 1'b1;
                        o_RegWrite  <= lat_regwrite;
                        o_rd        <= lat_rd;
                        o_WriteData <= lat_load ? ld_data : 32'h0;
                    end
                end
                default: begin
                    o_DmemReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory-access pipeline stage that consumes the execution stage's registered results (ALU output, rs2 value, destination register, memory/write-back controls). It performs loads and stores over a single-outstanding req/ack data-memory port. It aligns and byte-enables store data and extracts and sign- or zero-extends load data. It stalls the upstream pipeline while an access is in flight and registers the write-back inputs for the final stage.

## Interface
- No parameters; all widths are fixed (RV32).
- i_Clock  in  1  sole clock; all state updates on its rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Valid  in  1  upstream slot holds a real instruction.
- i_MemRead / i_MemWrite  in  1 / 1  load / store request; never both high.
- i_MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- i_MemUnsigned  in  1  zero-extend loads (LBU/LHU) when high.
- i_RegWrite  in  1  instruction writes rd.
- i_rd  in  5  destination register ID.
- i_AluOutput  in  32  effective address (memory ops) or result (others).
- i_rs2Value  in  32  store data.
- o_Stall  out  1  upstream must hold its outputs; combinational, high whenever FSM is not IDLE.
- o_DmemReq / o_DmemWe  out  1 / 1  request valid / write.
- o_DmemAddr  out  32  word address, bits [1:0] forced 0.
- o_DmemWdata  out  32  lane-replicated store data.
- o_DmemByteEn  out  4  active byte lanes.
- i_DmemAck  in  1  memory completes the current request this cycle.
- i_DmemRdata  in  32  read word, valid with i_DmemAck on loads.
- o_Valid / o_RegWrite / o_rd / o_WriteData  out  1/1/5/32  registered write-back slot.
- o_Misaligned  out  1  one-cycle misaligned-access flag, aligned with o_Valid.

## Operation
- Input accepted on a rising edge when i_Valid=1 and o_Stall=0. Inputs present while o_Stall=1 are ignored and must be held.
- Non-memory instruction (MemRead=MemWrite=0): next cycle o_Valid=1, o_RegWrite=i_RegWrite, o_rd=i_rd, o_WriteData=i_AluOutput.
- Memory instruction: address, data, size, signedness, rd and RegWrite are latched. FSM goes IDLE→REQ.
- The write-back slot emits a bubble (o_Valid=0) in every cycle that does not retire an instruction.
- REQ: o_DmemReq=1 with stable addr/we/wdata/byteen until i_DmemAck=1 is sampled. Then FSM→IDLE and the instruction retires next cycle:
  - Load: o_WriteData is the extracted lane. Byte = addr[1:0] lane; half = addr[1] halfword. Result is sign-extended unless unsigned.
  - Store: o_RegWrite=0.
- Store lanes:
  - byte: byteen = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - half: byteen = 0011<<(2*addr[1]), wdata = {2{rs2[15:0]}}.
  - word: byteen = 1111, wdata = rs2.
  - Loads drive o_DmemByteEn=1111, o_DmemWe=0.
- i_DmemAck while IDLE is ignored.
- No reordering, one access outstanding.

## Timing
- Reset (i_Reset_n=0 at an edge): FSM=IDLE; o_Valid, o_RegWrite, o_Misaligned, o_rd, o_WriteData = 0; o_DmemReq, o_DmemWe, o_DmemByteEn, o_DmemAddr, o_DmemWdata = 0; o_Stall=0.
- Reset mid-REQ abandons the access. o_DmemReq is low the cycle after the reset edge, and a late ack is ignored.
- Non-memory latency: 1 cycle, full throughput.
- Memory op: accepted at edge E0. o_DmemReq and o_Stall are high from E0. With ack sampled at edge Ek (k≥1), the result is valid after Ek and o_Stall is low after Ek. Minimum 2 cycles per memory instruction.
- Ack in the first REQ cycle is legal, and the zero-wait path must work.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 issues no bus request and does not stall. Next cycle: o_Valid=1, o_Misaligned=1, o_RegWrite=0.
- Not defined: o_Misaligned is tied 0. Sub-size address bits are ignored (half uses addr[1] only, word ignores addr[1:0]) and the access proceeds normally.

## Test plan
- Reset mid-REQ: drop i_Reset_n with o_DmemReq=1 → all outputs 0 after that edge; a subsequent ack produces no o_Valid.
- ADD result 0x0000_1234, rd=5 → one cycle later o_Valid=1, o_rd=5, o_WriteData=0x0000_1234, o_Stall never high.
- LB, addr 0x103, ack after 3 REQ cycles with rdata 0x80_11_22_33 → o_Stall high 3 cycles, o_WriteData=0xFFFF_FF80; LBU with the same stimulus gives 0x0000_0080.
- SH, addr 0x202, rs2 0xDEAD_BEEF, same-cycle ack → o_DmemAddr=0x200, byteen=1100, wdata=0xBEEF_BEEF, o_RegWrite=0 at retire.
- Back-to-back LW, LW, ADD with immediate acks → retire on three distinct cycles, in order; the held ADD is not accepted until o_Stall falls.
- LW addr 0x101: with DMEM_MISALIGN_TRAP_EN → no o_DmemReq, o_Misaligned=1 for one cycle; without it → request to 0x100, load retires normally.
